seg_display_monitor: RTL and testbench
======================================

# seg_display_monitor

Passive receiver for the stopwatch's multiplexed 4-digit seven-segment output. It samples the segment lines (a–g, dp) and the anode enables (an), waits for each scanned digit to settle, and decodes it back to BCD. It then presents a coherent 4-digit snapshot with a one-cycle frame strobe. It sits beside the display driver in self-checking benches and in on-chip readback/debug logic, and drives no display pins.

## Interface
- STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured (≥2).
- TIMEOUT_CYCLES, default 1024: cycles without any capture before `stale` asserts.
- clock  input  1  single system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- a, b, c, d, e, f, g  input  1 each  segment lines, active-low; seg vector is {a,b,c,d,e,f,g}, with a as the MSB.
- dp  input  1  decimal point, active-low.
- an  input  4  anode enables, active-low; an[0] is the rightmost digit (digit0).
- digit0..digit3  output  4 each  captured BCD value per position.
- blank  output  4  bit i set: position i was captured with all segments off.
- dp_mask  output  4  bit i set: dp was lit on position i.
- frame_valid  output  1  one-cycle strobe; the digit, blank and dp_mask outputs were just updated.
- seg_err  output  1  one-cycle pulse: an illegal segment pattern was captured.
- an_err  output  1  one-cycle pulse: the anode pattern is not one-hot-low and not all-high.
- stale  output  1  level; no capture for TIMEOUT_CYCLES cycles, or no frame since reset.

## Operation
- All inputs are registered once before use (sample stage S). Only S feeds the FSM and the decoder.
- Anode classes:
  - one-hot-low (exactly one bit 0) is active;
  - 4'b1111 is a blanking gap and is legal;
  - anything else is illegal.
- FSM states:
  - IDLE: waits for an active anode.
  - SETTLE: counts identical S samples.
  - HOLD: digit captured; waits for an or the segments to change.
- Transitions:
  - IDLE→SETTLE on an active anode; the counter loads 1.
  - SETTLE: if S equals the previous S, the counter increments. When the counter reaches STABLE_CYCLES, the digit is captured and the FSM goes to HOLD.
  - SETTLE: any change in an/seg/dp restarts the count at 1, or returns to IDLE if an becomes the blanking gap.
  - HOLD→SETTLE when an changes to a different active anode. HOLD→IDLE on the blanking gap. A segment change with the same anode does not cause a recapture.
  - An illegal an in any state pulses an_err, clears the position mask, and goes to IDLE.
- Decode (seg7_decode), active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - blank=1111111: value 0, blank bit set.
  - Any other pattern is illegal.
- Capture of position i:
  - a legal pattern writes a shadow digit register, the shadow blank bit and the shadow dp bit, and sets bit i of the 4-bit position mask;
  - an illegal pattern pulses seg_err, clears the mask, and writes nothing.
- Frame completion: when the mask becomes 4'b1111, the shadow registers are copied to the outputs atomically, frame_valid pulses, and the mask clears.
- Recapturing an already-masked position before the frame completes overwrites that position's shadow value (latest value wins).
- The timeout counter clears on every legal capture and saturates at TIMEOUT_CYCLES; `stale` is high while it is saturated.
- A completed frame clears `stale`.

## Timing
- Reset values:
  - digit0..3 = 0, blank = 4'b1111, dp_mask = 0;
  - frame_valid = 0, seg_err = 0, an_err = 0, stale = 1;
  - FSM in IDLE, mask 0, all counters 0.
- Reset mid-scan discards partial frames; there is no output update until four fresh captures complete.
- Capture latency: raw inputs constant from edge t are captured at edge t+1+STABLE_CYCLES.
- Frame latency: outputs and frame_valid update at the edge following the fourth capture. frame_valid is high for exactly that one cycle.
- seg_err and an_err are high for the one cycle after the offending S sample. A seg_err and a frame completion cannot occur on the same cycle.
- If capture and timeout saturation fall on the same edge, capture wins: stale stays low.

## Structure
- Package seg_pkg holds:
  - the state enum (IDLE, SETTLE, HOLD);
  - the 7-bit active-low pattern constants for 0–9 and blank;
  - the helper function that tests an anode vector for one-hot-low.
- Sub-module seg7_decode: combinational; inputs the 7-bit seg vector; outputs value[3:0], is_blank and illegal. It is instantiated once.
- The top level holds the sample stage, the FSM, the settle and timeout counters, the shadow and output registers, and the mask.

## Test plan
- Reset release with inputs idle (an=1111): hold 50 cycles → all outputs at reset values, stale=1, no strobes.
- Scan digits 1,2,3,4 (an=1110,1101,1011,0111), each held 20 cycles, seg patterns as decoded, dp lit on an[2] → one frame_valid; digit3..0 = 4,3,2,1 (digit0=1 ... digit3=4); dp_mask=0100; blank=0000; stale=0.
- Glitch: the segments toggle every 2 cycles for 10 cycles on an=1110 (STABLE_CYCLES=4), then hold 0000100 → exactly one capture, of 9, issued 5 cycles after the last change.
- Illegal pattern 1111110 on digit1 mid-frame → seg_err one cycle; no frame_valid until a full new four-digit scan; the outputs keep the previous frame.
- an=1100 during a scan → an_err one cycle; mask cleared; the next complete scan produces a correct frame.
- Stop scanning after one frame for TIMEOUT_CYCLES+5 cycles → stale rises exactly TIMEOUT_CYCLES cycles after the last capture; the digits hold their values; reset asserted mid-scan returns every output to its reset value on the next edge.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment readback monitor.
// Holds the FSM states, active-low segment patterns and the anode one-hot-low test.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  // Active-low {a,b,c,d,e,f,g}, a is the MSB
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic an_onehot_low(input logic [3:0] an);
    return (an == 4'b1110) || (an == 4'b1101) ||
           (an == 4'b1011) || (an == 4'b0111);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low seven-segment to BCD decoder.
// Ports: seg {a..g} in; value BCD, is_blank (all off), illegal (unknown pattern) out.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       is_blank,
  output logic       illegal
);

  always_comb begin
    value    = 4'd0;
    is_blank = 1'b0;
    illegal  = 1'b0;
    unique case (1'b1)
      (seg == SEG_0):     value = 4'd0;
      (seg == SEG_1):     value = 4'd1;
      (seg == SEG_2):     value = 4'd2;
      (seg == SEG_3):     value = 4'd3;
      (seg == SEG_4):     value = 4'd4;
      (seg == SEG_5):     value = 4'd5;
      (seg == SEG_6):     value = 4'd6;
      (seg == SEG_7):     value = 4'd7;
      (seg == SEG_8):     value = 4'd8;
      (seg == SEG_9):     value = 4'd9;
      (seg == SEG_BLANK): is_blank = 1'b1;
      default:            illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_display_monitor.sv
// Passive receiver for a multiplexed 4-digit seven-segment display.
// In: clock, reset, a..g, dp (active-low), an[3:0] (active-low).
// Out: digit0..3, blank, dp_mask, frame_valid, seg_err, an_err, stale.
module seg_display_monitor
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       dp,
  input  logic [3:0] an,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] blank,
  output logic [3:0] dp_mask,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       an_err,
  output logic       stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT_CYCLES);

  // Sample stage S and its previous value
  logic [6:0] r_s_seg;
  logic       r_s_dp;
  logic [3:0] r_s_an;
  logic [6:0] r_p_seg;
  logic       r_p_dp;
  logic [3:0] r_p_an;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [TW-1:0]   r_tcnt;
  logic [3:0]      r_mask;
  logic [3:0]      r_sh_dig [4];
  logic [3:0]      r_sh_blank;
  logic [3:0]      r_sh_dp;
  logic [3:0]      r_dig [4];
  logic [3:0]      r_blank;
  logic [3:0]      r_dp_mask;
  logic            r_fv;
  logic            r_seg_err;
  logic            r_an_err;
  logic            r_no_frame;

  state_t          w_state_n;
  logic [CW-1:0]   w_cnt_n;
  logic            w_capture;
  logic            w_an_act;
  logic            w_an_gap;
  logic            w_an_bad;
  logic            w_same;
  logic [1:0]      w_pos;
  logic [3:0]      w_value;
  logic            w_is_blank;
  logic            w_illegal;
  logic            w_cap_ok;
  logic            w_cap_bad;
  logic            w_full;
  logic [3:0]      w_mask_n;

  assign w_an_act  = an_onehot_low(r_s_an);
  assign w_an_gap  = (r_s_an == 4'b1111);
  assign w_an_bad  = !w_an_act && !w_an_gap;
  assign w_same    = ({r_s_an, r_s_seg, r_s_dp} ==
                      {r_p_an, r_p_seg, r_p_dp});
  assign w_cap_ok  = w_capture && !w_illegal;
  assign w_cap_bad = w_capture && w_illegal;
  assign w_full    = (r_mask == 4'b1111);

  seg7_decode u_dec (
    .seg      (r_s_seg),
    .value    (w_value),
    .is_blank (w_is_blank),
    .illegal  (w_illegal)
  );

  always_comb begin
    w_pos = 2'd0;
    unique case (1'b1)
      (r_s_an == 4'b1101): w_pos = 2'd1;
      (r_s_an == 4'b1011): w_pos = 2'd2;
      (r_s_an == 4'b0111): w_pos = 2'd3;
      default:             w_pos = 2'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s_seg <= SEG_BLANK;
      r_s_dp  <= 1'b1;
      r_s_an  <= 4'b1111;
      r_p_seg <= SEG_BLANK;
      r_p_dp  <= 1'b1;
      r_p_an  <= 4'b1111;
    end else begin
      r_s_seg <= {a, b, c, d, e, f, g};
      r_s_dp  <= dp;
      r_s_an  <= an;
      r_p_seg <= r_s_seg;
      r_p_dp  <= r_s_dp;
      r_p_an  <= r_s_an;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_capture = 1'b0;
    if (w_an_bad) begin
      w_state_n = ST_IDLE;
      w_cnt_n   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_an_act) begin
            w_state_n = ST_SETTLE;
            w_cnt_n   = CW'(1);
          end
        end
        ST_SETTLE: begin
          if (w_an_gap) begin
            w_state_n = ST_IDLE;
            w_cnt_n   = '0;
          end else if (!w_same) begin
            w_cnt_n = CW'(1);
          end else if (r_cnt == CNT_LAST) begin
            w_capture = 1'b1;
            w_state_n = ST_HOLD;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          if (w_an_gap) begin
            w_state_n = ST_IDLE;
          end else if (r_s_an != r_p_an) begin
            w_state_n = ST_SETTLE;
            w_cnt_n   = CW'(1);
          end
        end
        default: begin
          w_state_n = ST_IDLE;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  // A full mask is consumed on the next edge, so a capture there starts afresh
  always_comb begin
    w_mask_n = w_full ? 4'b0000 : r_mask;
    if (w_an_bad || w_cap_bad) begin
      w_mask_n = 4'b0000;
    end else if (w_cap_ok) begin
      w_mask_n = w_mask_n | (4'b0001 << w_pos);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mask     <= 4'b0000;
      r_sh_blank <= 4'b1111;
      r_sh_dp    <= 4'b0000;
      r_blank    <= 4'b1111;
      r_dp_mask  <= 4'b0000;
      r_fv       <= 1'b0;
      r_seg_err  <= 1'b0;
      r_an_err   <= 1'b0;
      r_no_frame <= 1'b1;
      r_tcnt     <= '0;
      for (int i = 0; i < 4; i++) begin
        r_sh_dig[i] <= 4'd0;
        r_dig[i]    <= 4'd0;
      end
    end else begin
      r_mask    <= w_mask_n;
      r_fv      <= w_full;
      r_seg_err <= w_cap_bad;
      r_an_err  <= w_an_bad;
      if (w_cap_ok) begin
        r_sh_dig[w_pos]   <= w_value;
        r_sh_blank[w_pos] <= w_is_blank;
        r_sh_dp[w_pos]    <= ~r_s_dp;
      end
      if (w_full) begin
        r_dig      <= r_sh_dig;
        r_blank    <= r_sh_blank;
        r_dp_mask  <= r_sh_dp;
        r_no_frame <= 1'b0;
      end
      // Capture wins over saturation on the same edge
      if (w_cap_ok) begin
        r_tcnt <= '0;
      end else if (r_tcnt != T_MAX) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
    end
  end

  assign digit0      = r_dig[0];
  assign digit1      = r_dig[1];
  assign digit2      = r_dig[2];
  assign digit3      = r_dig[3];
  assign blank       = r_blank;
  assign dp_mask     = r_dp_mask;
  assign frame_valid = r_fv;
  assign seg_err     = r_seg_err;
  assign an_err      = r_an_err;
  assign stale       = r_no_frame || (r_tcnt == T_MAX);

endmodule

// File: tb/tb_seg_display_monitor.sv
// Directed bench for seg_display_monitor with an expected-frame queue.
// Drives scanned digits and checks frames, error pulses and stale timing.
module tb_seg_display_monitor;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 1024;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       a, b, c, d, e, f, g, dp;
  logic [3:0] an;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] blank, dp_mask;
  logic       frame_valid, seg_err, an_err, stale;

  always #5 clock = ~clock;

  seg_display_monitor #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .e           (e),
    .f           (f),
    .g           (g),
    .dp          (dp),
    .an          (an),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .blank       (blank),
    .dp_mask     (dp_mask),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .an_err      (an_err),
    .stale       (stale)
  );

  // {d3,d2,d1,d0,blank,dp_mask}
  typedef logic [23:0] frame_t;

  frame_t exp_q[$];
  frame_t m_exp;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_fv = 0;
  int n_se = 0;
  int n_ae = 0;
  int fv_cyc = 0;
  int drive_cyc = 0;
  int target = 0;

  // index 10 is the all-off pattern
  logic [6:0] pat [0:10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b1111111
  };

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (frame_valid === 1'b1) begin
      n_fv++;
      fv_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("frame_unexpected", 32'd1, 32'd0);
      end else begin
        m_exp = exp_q.pop_front();
        chk("frame", {8'd0, digit3, digit2, digit1, digit0,
                      blank, dp_mask}, {8'd0, m_exp});
      end
    end
    if (seg_err === 1'b1) n_se++;
    if (an_err === 1'b1) n_ae++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input int val, input int pos, input bit dpon);
    {a, b, c, d, e, f, g} = pat[val];
    dp = ~dpon;
    an = 4'b1111;
    an[pos] = 1'b0;
  endtask

  task automatic show(input int val, input int pos, input bit dpon,
                      input int n);
    drive(val, pos, dpon);
    step(n);
  endtask

  task automatic gap(input int n);
    {a, b, c, d, e, f, g} = 7'b1111111;
    dp = 1'b1;
    an = 4'b1111;
    step(n);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_digits"}, {digit3, digit2, digit1, digit0}, 16'h0000);
    chk({tag, "_blank"}, blank, 4'b1111);
    chk({tag, "_dpmask"}, dp_mask, 4'b0000);
    chk({tag, "_strobes"}, {frame_valid, seg_err, an_err}, 3'b000);
    chk({tag, "_stale"}, stale, 1'b1);
  endtask

  initial begin
    {a, b, c, d, e, f, g} = 7'b1111111;
    dp = 1'b1;
    an = 4'b1111;
    reset = 1'b1;
    step(3);
    chk_reset_state("reset");
    reset = 1'b0;
    gap(50);
    chk_reset_state("idle");
    chk("idle_pulses", n_fv + n_se + n_ae, 0);

    // Basic scan, dp on position 2
    exp_q.push_back({4'd4, 4'd3, 4'd2, 4'd1, 4'b0000, 4'b0100});
    show(1, 0, 0, 20);
    show(2, 1, 0, 20);
    show(3, 2, 1, 20);
    show(4, 3, 0, 20);
    gap(10);
    chk("scan1_frames", n_fv, 1);
    chk("scan1_stale", stale, 1'b0);

    // Minimum hold of STABLE cycles captures
    exp_q.push_back({4'd8, 4'd7, 4'd6, 4'd5, 4'b0000, 4'b0000});
    show(5, 0, 0, STABLE);
    show(6, 1, 0, STABLE);
    show(7, 2, 0, STABLE);
    show(8, 3, 0, STABLE);
    gap(10);
    chk("min_hold_frames", n_fv, 2);

    // One cycle short on the last digit: no capture
    show(1, 0, 0, STABLE);
    show(2, 1, 0, STABLE);
    show(3, 2, 0, STABLE);
    show(4, 3, 0, STABLE - 1);
    gap(10);
    chk("short_hold_frames", n_fv, 2);
    exp_q.push_back({4'd9, 4'd3, 4'd2, 4'd1, 4'b0000, 4'b0000});
    show(9, 3, 0, STABLE);
    gap(10);
    chk("short_fix_frames", n_fv, 3);

    // Glitching digit0 as the fourth capture
    exp_q.push_back({4'd2, 4'd7, 4'd4, 4'd9, 4'b0000, 4'b0000});
    show(2, 3, 0, 20);
    show(7, 2, 0, 20);
    show(4, 1, 0, 20);
    for (int i = 0; i < 5; i++) show((i % 2) ? 1 : 8, 0, 0, 2);
    drive(9, 0, 0);
    drive_cyc = cyc;
    step(20);
    gap(10);
    chk("glitch_frames", n_fv, 4);
    chk("glitch_latency", fv_cyc - drive_cyc, 1 + STABLE + 1);

    // Illegal pattern on digit1
    show(5, 0, 0, 20);
    {a, b, c, d, e, f, g} = 7'b1111110;
    dp = 1'b1;
    an = 4'b1101;
    step(20);
    gap(10);
    chk("segerr_pulses", n_se, 1);
    chk("segerr_frames", n_fv, 4);
    chk("segerr_hold", {digit3, digit2, digit1, digit0}, 16'h2749);

    // Recapture, dp and blank digit
    exp_q.push_back({4'd0, 4'd3, 4'd5, 4'd6, 4'b1000, 4'b0011});
    show(2, 0, 0, 20);
    show(5, 1, 1, 20);
    show(6, 0, 1, 20);
    show(3, 2, 0, 20);
    show(10, 3, 0, 20);
    gap(10);
    chk("recap_frames", n_fv, 5);

    // Illegal anode mid-scan
    show(1, 0, 0, 20);
    show(2, 1, 0, 20);
    drive(3, 2, 0);
    an = 4'b1100;
    step(1);
    gap(10);
    chk("anerr_pulses", n_ae, 1);
    chk("anerr_frames", n_fv, 5);
    exp_q.push_back({4'd8, 4'd0, 4'd4, 4'd7, 4'b0000, 4'b0000});
    show(7, 0, 0, 20);
    show(4, 1, 0, 20);
    show(0, 2, 0, 20);
    show(8, 3, 0, 20);
    gap(5);
    chk("anerr_next_frames", n_fv, 6);

    // Timeout after the last capture (one edge before the frame strobe)
    target = fv_cyc + TIMEOUT - 2;
    while (cyc < target) step(1);
    chk("stale_before", stale, 1'b0);
    step(1);
    chk("stale_rise", stale, 1'b1);
    step(5);
    chk("stale_hold", {digit3, digit2, digit1, digit0}, 16'h8047);

    // Reset mid-scan
    show(1, 0, 0, 20);
    show(2, 1, 0, 3);
    reset = 1'b1;
    step(1);
    chk_reset_state("midreset");
    reset = 1'b0;
    show(3, 2, 0, 20);
    show(4, 3, 0, 20);
    gap(10);
    chk("midreset_partial", n_fv, 6);
    exp_q.push_back({4'd4, 4'd3, 4'd6, 4'd5, 4'b0000, 4'b0000});
    show(5, 0, 0, 20);
    show(6, 1, 0, 20);
    gap(10);
    chk("midreset_frames", n_fv, 7);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
